// File: rtl/fdtd_ez_writeback_if.sv
// rtl/fdtd_ez_writeback_if.sv - data-select request/sample and Ez memory write bundle
interface fdtd_ez_writeback_if #(
  parameter int FDTD_DATA_WIDTH = 80,
  parameter int ADDR_WIDTH      = 6
);
  logic                              calc_Ez_en_o;
  logic                              calc_src_en_o;
  logic signed [FDTD_DATA_WIDTH-1:0] Ez_n_i;
  logic                              mem_we_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic signed [FDTD_DATA_WIDTH-1:0] mem_wdata_o;
  logic                              mem_ready_i;

  // Sweep controller side: issues requests, consumes samples, writes memory
  modport master (
    output calc_Ez_en_o, calc_src_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  Ez_n_i, mem_ready_i
  );

  // Select stage plus field memory side
  modport slave (
    input  calc_Ez_en_o, calc_src_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output Ez_n_i, mem_ready_i
  );
endinterface

// File: rtl/fdtd_ez_writeback.sv
// rtl/fdtd_ez_writeback.sv - Ez sweep controller with write-back FIFO
module fdtd_ez_writeback #(
  parameter int FDTD_DATA_WIDTH = 80,
  parameter int NX              = 64,
  parameter int ADDR_WIDTH      = 6,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  fdtd_ez_writeback_if.master   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(NX - 1);
  localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_WIDTH-1:0]      r_cell;
  logic [ADDR_WIDTH-1:0]      r_src_addr;
  logic [ADDR_WIDTH-1:0]      r_fifo_addr [FIFO_DEPTH];
  logic [FDTD_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;

  logic w_start;
  logic w_issue;
  logic w_is_src;
  logic w_nempty;
  logic w_pop;

  // Issue gating uses only the registered count, so a same-cycle pop never
  // frees a slot for an extra request.
  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_issue  = (r_state == S_ISSUE) && (r_count < FIFO_FULL);
  assign w_is_src = (r_cell == r_src_addr);
  assign w_nempty = (r_count != '0);
  assign w_pop    = w_nempty && bus.mem_ready_i;

  assign bus.calc_src_en_o = w_issue && w_is_src;
  assign bus.calc_Ez_en_o  = w_issue && !w_is_src;

  // Head is masked to zero when empty so the write bus is quiet at reset.
  assign bus.mem_we_o    = w_nempty;
  assign bus.mem_addr_o  = w_nempty ? r_fifo_addr[r_rd_ptr] : '0;
  assign bus.mem_wdata_o = w_nempty ? r_fifo_data[r_rd_ptr] : '0;

  assign busy_o = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done_o = (r_state == S_DONE);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the sweep sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue && (r_cell == LAST_CELL)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_nempty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cell counter and source-cell latch, both restarted on an accepted start
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cell     <= '0;
      r_src_addr <= '0;
    end else if (w_start) begin
      r_cell     <= '0;
      r_src_addr <= src_addr_i;
    end else if (w_issue) begin
      r_cell     <= r_cell + 1'b1;
    end
  end

  // FIFO storage: each issued request captures its cell index and sample
  always_ff @(posedge CLK) begin
    if (w_issue) begin
      r_fifo_addr[r_wr_ptr] <= r_cell;
      r_fifo_data[r_wr_ptr] <= bus.Ez_n_i;
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fdtd_ez_writeback.sv
// tb/tb_fdtd_ez_writeback.sv - randomized self-checking bench for fdtd_ez_writeback
module tb_fdtd_ez_writeback;
  localparam int W     = 80;
  localparam int NX    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0;
  logic          busy_o;
  logic          done_o;

  fdtd_ez_writeback_if #(.FDTD_DATA_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  fdtd_ez_writeback #(
    .FDTD_DATA_WIDTH(W),
    .NX(NX),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start_i(start_i),
    .src_addr_i(src_addr_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Select stage model: sample chosen by which enable is high and by the
  // bench's own running request index within the sweep.
  logic [W-1:0] ez_tab [NX];
  logic [W-1:0] src_val = '0;
  int           req_idx = 0;
  logic         clr_idx = 1'b0;
  logic         r_ready = 1'b0;
  int           mode    = 0;

  always @(posedge CLK) begin
    if (RST || clr_idx) req_idx <= 0;
    else if (bus.calc_Ez_en_o || bus.calc_src_en_o) req_idx <= req_idx + 1;
  end

  always_comb begin
    bus.Ez_n_i = '0;
    if (bus.calc_src_en_o) bus.Ez_n_i = src_val;
    else if (bus.calc_Ez_en_o && req_idx < NX) bus.Ez_n_i = ez_tab[req_idx];
  end

  assign bus.mem_ready_i = r_ready;

  // Reference expectations and monitor state
  wr_t exp_q[$];
  int  exp_src   = 0;
  int  occ       = 0;
  int  n_req     = 0;
  int  n_src_req = 0;
  int  n_wr      = 0;
  int  n_done    = 0;
  logic          stall     = 1'b0;
  logic          prev_busy = 1'b0;
  logic [AW-1:0] hold_a    = '0;
  logic [W-1:0]  hold_d    = '0;

  always @(negedge CLK) begin
    wr_t e;
    if (RST) begin
      occ       = 0;
      stall     = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_we", bus.mem_we_o, 1);
        chk("hold_addr", bus.mem_addr_o, hold_a);
        chk("hold_data", $unsigned(bus.mem_wdata_o), hold_d);
      end
      if (bus.calc_Ez_en_o || bus.calc_src_en_o) begin
        chk("en_onehot", bus.calc_Ez_en_o & bus.calc_src_en_o, 0);
        chk("req_room", occ < DEPTH, 1);
        chk("req_idx_range", req_idx < NX, 1);
        if (bus.calc_src_en_o) begin
          chk("src_idx", req_idx, exp_src);
          n_src_req++;
        end else begin
          chk("ez_not_src", req_idx == exp_src, 0);
        end
        n_req++;
        occ++;
      end
      if (bus.mem_we_o && bus.mem_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr_o, e.a);
          chk("wr_data", $unsigned(bus.mem_wdata_o), e.d);
        end
        n_wr++;
        occ--;
      end
      stall  = bus.mem_we_o && !bus.mem_ready_i;
      hold_a = bus.mem_addr_o;
      hold_d = $unsigned(bus.mem_wdata_o);
      if (done_o) begin
        n_done++;
        chk("done_busy_low", busy_o, 0);
        chk("done_after_busy", prev_busy, 1);
      end
      prev_busy = busy_o;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    case (mode)
      0:       r_ready = 1'b1;
      1:       r_ready = 1'($urandom_range(0, 1));
      default: r_ready = 1'b0;
    endcase
  endtask

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic load_tab(input bit rnd);
    for (int i = 0; i < NX; i++) ez_tab[i] = rnd ? rand_w() : W'(32'h100 + i);
    src_val = rnd ? rand_w() : W'(32'hABC);
  endtask

  task automatic begin_sweep(input int src);
    wr_t e;
    exp_q.delete();
    exp_src = src;
    for (int i = 0; i < NX; i++) begin
      e.a = AW'(i);
      e.d = (i == src) ? src_val : ez_tab[i];
      exp_q.push_back(e);
    end
    n_req = 0; n_src_req = 0; n_wr = 0; n_done = 0;
    src_addr_i = AW'(src);
    start_i    = 1'b1;
    clr_idx    = 1'b1;
    tick();
    start_i = 1'b0;
    clr_idx = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done_o && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("done_seen", done_o, 1);
  endtask

  task automatic end_sweep(input int src, input bit pulse_start);
    if (pulse_start) start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("done_pulse", done_o, 0);
    chk("busy_idle", busy_o, 0);
    chk("n_done", n_done, 1);
    chk("n_wr", n_wr, NX);
    chk("q_empty", exp_q.size(), 0);
    chk("n_req", n_req, NX);
    chk("n_src_req", n_src_req, (src < NX) ? 1 : 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ez_en"}, bus.calc_Ez_en_o, 0);
    chk({tag, "_src_en"}, bus.calc_src_en_o, 0);
    chk({tag, "_we"}, bus.mem_we_o, 0);
    chk({tag, "_addr"}, bus.mem_addr_o, 0);
    chk({tag, "_wdata"}, $unsigned(bus.mem_wdata_o), 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    int cyc;
    int src;
    int k;

    mode = 0;
    RST  = 1'b1;
    repeat (3) tick();
    chk_quiet("rst");
    RST = 1'b0;
    tick();

    // Basic sweep with fixed select data
    load_tab(0);
    begin_sweep(3);
    chk("c1_busy", busy_o, 1);
    chk("c1_ez_en", bus.calc_Ez_en_o, 1);
    wait_done(cyc);
    chk("done_cycle", cyc, NX + 3);
    end_sweep(3, 0);

    // Backpressure: memory stalls for ten cycles
    mode = 2;
    tick();
    begin_sweep(3);
    repeat (9) tick();
    chk("bp_nreq", n_req, DEPTH);
    chk("bp_ez_en", bus.calc_Ez_en_o, 0);
    chk("bp_src_en", bus.calc_src_en_o, 0);
    chk("bp_we", bus.mem_we_o, 1);
    chk("bp_addr", bus.mem_addr_o, 0);
    chk("bp_data", $unsigned(bus.mem_wdata_o), ez_tab[0]);
    mode = 0;
    wait_done(cyc);
    end_sweep(3, 0);

    // Source address beyond the grid
    begin_sweep(NX);
    wait_done(cyc);
    end_sweep(NX, 0);

    // Start pulses during ISSUE and DONE are ignored
    begin_sweep(3);
    tick();
    tick();
    src_addr_i = AW'(5);
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(cyc);
    src_addr_i = AW'(0);
    end_sweep(3, 1);
    tick();
    chk("no_restart_busy", busy_o, 0);
    chk("no_restart_req", n_req, NX);

    // Reset in the middle of a sweep under toggling ready
    mode = 1;
    load_tab(1);
    begin_sweep(5);
    k = 0;
    while (n_wr < 3 && k < 500) begin
      tick();
      k++;
    end
    chk("mid_wr3", n_wr >= 3, 1);
    RST = 1'b1;
    tick();
    chk_quiet("mid_rst");
    exp_q.delete();
    RST = 1'b0;
    tick();
    load_tab(1);
    begin_sweep(2);
    wait_done(cyc);
    end_sweep(2, 0);

    // Random sweeps with 50% ready
    for (int s = 0; s < 20; s++) begin
      load_tab(1);
      src = $urandom_range(0, NX + 1);
      begin_sweep(src);
      wait_done(cyc);
      end_sweep(src, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
